// File: rtl/serial_tx_fifo.sv
// Serial byte transmitter (start, 8 data bits LSB first, stop) fed by a small circular FIFO.
// Define SERIAL_TX_PARITY_EN to insert an even parity bit between bit 7 and the stop bit.
module serial_tx_fifo #(
    parameter int CLK_PER_BIT = 50,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       new_data,
    input  logic       block,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       overflow
);

    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [PW:0]   DEPTH_CNT = (PW+1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef SERIAL_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic          push, pop, bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    // State register and control flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Datapath storage needs no reset: it is only read after being loaded
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
`ifdef SERIAL_TX_PARITY_EN
        parity_q <= parity_d;
`endif
        if (push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    // full is judged before any pop this cycle, so a simultaneous pop cannot rescue a write
    always_comb begin
        push       = new_data && !full;
        overflow_d = overflow_q || (new_data && full);
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + CW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        bit_end   = (bit_cnt_q == BIT_LAST);
`ifdef SERIAL_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                if ((count_q != '0) && !block) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_idx_d = '0;
                    state_d   = S_START;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d  = ^mem_q[rd_ptr_q];
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                bit_cnt_d = '0;
                bit_idx_d = '0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // tx is registered from the next state so the line level changes on the same edge as the state
    always_comb begin
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx       = tx_q;
    assign full     = (count_q == DEPTH_CNT);
    assign busy     = (state_q != S_IDLE) || (count_q != '0);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Directed bench for serial_tx_fifo: framing, back-to-back, overflow, flow control, async reset.
module tb_serial_tx_fifo;

    localparam int N = 50;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       new_data = 1'b0;
    logic       block = 1'b0;
    logic       tx, busy, full, overflow;

    int checks = 0;
    int errors = 0;
    logic [7:0] wq [$];

    serial_tx_fifo #(.CLK_PER_BIT(N), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .new_data(new_data), .block(block),
        .tx(tx), .busy(busy), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input logic par, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == 9 && FRAME_BITS == 11) return par;
        return 1'b1;
    endfunction

    // Entered just after the edge on which tx fell; ends on the last sample of the stop bit.
    task automatic frame_check(input logic [7:0] b, input logic par, input int raise_at);
        int   i;
        logic bad;
        logic bad_val;
        for (int bit_i = 0; bit_i < FRAME_BITS; bit_i++) begin
            bad = 1'b0;
            bad_val = 1'b0;
            for (int c = 0; c < N; c++) begin
                i = bit_i * N + c;
                if (i > 0) begin
                    if (wq.size() > 0) begin
                        data = wq.pop_front();
                        new_data = 1'b1;
                    end else begin
                        new_data = 1'b0;
                    end
                    if (i == raise_at) block = 1'b1;
                    step();
                end
                if (tx !== exp_bit(b, par, bit_i) && !bad) begin
                    bad = 1'b1;
                    bad_val = tx;
                end
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL frame_%h bit %0d: tx=%b expected %b", b, bit_i, bad_val, exp_bit(b, par, bit_i));
            end
        end
        new_data = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        data = 8'hA5;
        new_data = 1'b1;
        step();
        new_data = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_after_write: got %b want 1", busy); end
        checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL single_tx_before_pop: got %b want 1", tx); end
        step();
        checks++; if (tx !== 1'b0)   begin errors++; $display("FAIL single_tx_fall: got %b want 0", tx); end
        frame_check(8'hA5, 1'b0, -1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_in_stop: got %b want 1", busy); end
        step();
        checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL single_tx_idle: got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [4];
        logic       pars [4];
        bytes = '{8'h00, 8'hFF, 8'h55, 8'h3C};
        pars  = '{1'b0, 1'b0, 1'b0, 1'b0};
        data = bytes[0];
        new_data = 1'b1;
        step();
        data = bytes[1];
        step();
        wq.push_back(bytes[2]);
        wq.push_back(bytes[3]);
        for (int j = 0; j < 4; j++) begin
            frame_check(bytes[j], pars[j], -1);
            if (j < 3) begin
                step();
                checks++; if (tx !== 1'b1) begin errors++; $display("FAIL b2b_idle_%0d: tx=%b want 1", j, tx); end
                step();
                checks++; if (tx !== 1'b0) begin errors++; $display("FAIL b2b_gap_%0d: tx=%b want 0", j, tx); end
            end
        end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_overflow();
        logic [7:0] bytes [5];
        logic       pars [4];
        logic       bad;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h99};
        pars  = '{1'b0, 1'b0, 1'b0, 1'b0};
        block = 1'b1;
        for (int j = 0; j < 5; j++) begin
            data = bytes[j];
            new_data = 1'b1;
            step();
            if (j == 2) begin
                checks++; if (full !== 1'b0) begin errors++; $display("FAIL ovf_full_after_3: got %b want 0", full); end
            end
            if (j == 3) begin
                checks++; if (full !== 1'b1)     begin errors++; $display("FAIL ovf_full_after_4: got %b want 1", full); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_flag_after_4: got %b want 0", overflow); end
            end
        end
        new_data = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag_after_5: got %b want 1", overflow); end
        checks++; if (full !== 1'b1)     begin errors++; $display("FAIL ovf_full_after_5: got %b want 1", full); end
        checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL ovf_blocked_tx: got %b want 1", tx); end
        block = 1'b0;
        step();
        checks++; if (tx !== 1'b0)   begin errors++; $display("FAIL ovf_start: tx=%b want 0", tx); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL ovf_full_after_pop: got %b want 0", full); end
        for (int j = 0; j < 4; j++) begin
            frame_check(bytes[j], pars[j], -1);
            step();
            if (j < 3) step();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy_end: got %b want 0", busy); end
        bad = 1'b0;
        for (int c = 0; c < 2 * N; c++) begin
            step();
            if (tx !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL ovf_fifth_sent: tx left idle, want stays 1"); end
    endtask

    task automatic test_flow_control();
        logic bad;
        data = 8'h81;
        new_data = 1'b1;
        step();
        new_data = 1'b0;
        step();
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL flow_start: tx=%b want 0", tx); end
        wq.push_back(8'h42);
        frame_check(8'h81, 1'b0, 2 * N + 10);
        step();
        checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL flow_idle_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flow_busy_queued: got %b want 1", busy); end
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (tx !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL flow_blocked: tx left idle, want stays 1"); end
        block = 1'b0;
        step();
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL flow_release: tx=%b want 0", tx); end
        frame_check(8'h42, 1'b0, -1);
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flow_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        logic bad;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL rstmid_overflow_sticky: got %b want 1", overflow); end
        data = 8'hF0;
        new_data = 1'b1;
        step();
        data = 8'h11;
        step();
        new_data = 1'b0;
        for (int c = 0; c < 4 * N + 20; c++) step();
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rstmid_bit3: tx=%b want 0", tx); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL rstmid_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (full !== 1'b0)     begin errors++; $display("FAIL rstmid_full: got %b want 0", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_overflow: got %b want 0", overflow); end
        step();
        step();
        rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 12 * N; c++) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL rstmid_no_frame: line or busy active after reset"); end
    endtask

`ifdef SERIAL_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] bytes [2];
        logic       pars [2];
        bytes = '{8'h07, 8'h03};
        pars  = '{1'b1, 1'b0};
        for (int j = 0; j < 2; j++) begin
            data = bytes[j];
            new_data = 1'b1;
            step();
            new_data = 1'b0;
            step();
            frame_check(bytes[j], pars[j], -1);
            step();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL parity_len_%0d: busy=%b want 0 after 550", j, busy); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_flow_control();
`ifdef SERIAL_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
